stream_argmax: RTL and testbench
================================

// Module: stream_argmax
// PURPOSE
//  Streaming reduction comparator for the DNN datapath: consumes a packet of WIDTH-bit
//  operands over a valid/ready stream and returns the extreme value (max or min) and the
//  index of its first occurrence. Compares signed or unsigned per packet.
//  Sits behind the output-layer accumulator (classification argmax) and in pooling paths.
// PARAMETERS
//  WIDTH   32  operand width in bits (>=2)
//  IDX_W   8   index/count width; a packet holds at most 2**IDX_W elements
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        in_data/in_last/u_mod/min_mode valid
//  in_ready   out  1        block accepts a beat this cycle
//  in_data    in   WIDTH    operand
//  in_last    in   1        final beat of packet
//  u_mod      in   1        1: unsigned compare, 0: two's-complement signed; sampled on first beat
//  min_mode   in   1        1: track minimum, 0: track maximum; sampled on first beat
//  out_valid  out  1        result valid, held until out_ready
//  out_ready  in   1        consumer takes the result
//  out_val    out  WIDTH    extreme value of the packet
//  out_idx    out  IDX_W    0-based index of its first occurrence
//  out_cnt    out  IDX_W+1  number of beats accepted in the packet, saturating at 2**IDX_W
//  out_ovf    out  1        packet exceeded 2**IDX_W beats
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; out_valid=0, out_val=0, out_idx=0, out_cnt=0,
//   out_ovf=0, in_ready=0 while rst_n low, 1 from first clock after release.
//  Accept = in_valid & in_ready. in_ready = (state != DONE). Inputs are ignored otherwise.
//  FSM:
//   IDLE: on accept: best<=in_data, idx<=0, cnt<=1, ovf<=0, latch u_mod/min_mode.
//         in_last=1 -> DONE, else -> ACC.
//   ACC:  on accept with cnt < 2**IDX_W: compare in_data against best in the latched mode.
//         Replace (best<=in_data, idx<=cnt[IDX_W-1:0]) only if strictly greater (max) or
//         strictly less (min); ties keep the earlier index. cnt<=cnt+1.
//         Accept with cnt == 2**IDX_W: beat is discarded (not compared), ovf<=1, cnt holds.
//         in_last on any accepted beat -> DONE.
//   DONE: out_valid=1; out_val/out_idx/out_cnt/out_ovf stable, no beat accepted.
//         out_ready=1 -> IDLE, out_valid=0 next cycle.
//  Latency: out_valid rises the cycle after the in_last beat is accepted. Single-beat packet:
//   IDLE->DONE directly, out_idx=0, out_cnt=1. A new packet is accepted no earlier than the
//   cycle after the result handoff (1 bubble per packet).
//  Compare: unsigned = magnitude over all WIDTH bits. Signed = MSB-inverted unsigned compare,
//   so a negative value is less than any non-negative value.
//  u_mod/min_mode changes mid-packet have no effect; the latched values apply until DONE exits.
//  Outputs in IDLE/ACC hold the last delivered result (out_valid=0); they are only
//   meaningful while out_valid=1.
//  Reset mid-packet or in DONE: partial result and pending output are dropped and the
//   outputs return to their reset values.
// TESTING
//  1 u_mod=0, max: {5, -3, 7, 7, 2}, last on 2 -> out_val=7, out_idx=2, out_cnt=5, ovf=0.
//  2 u_mod=1, max: {32'h0000_0001, 32'hFFFF_FFFF} -> out_val=FFFF_FFFF, idx=1;
//    same data with u_mod=0 -> out_val=1, idx=0.
//  3 min_mode=1, signed: {0, -8, 4, -8} -> out_val=-8, out_idx=1; single beat {9} -> idx=0, cnt=1.
//  4 IDX_W=2, max: 6 beats {1,2,3,4,9,9} -> out_val=4, out_idx=3, out_cnt=4, out_ovf=1.
//  5 Hold out_ready=0 for 5 cycles after result: out_valid and outputs stable, in_ready=0,
//    in_valid ignored; out_ready=1 -> next packet accepted the following cycle.
//  6 Deassert rst_n mid-packet after 3 beats: out_valid=0 immediately; new packet {3}
//    -> out_val=3, idx=0, cnt=1 (no carry-over).

Source files
------------

// File: rtl/stream_argmax.sv
// Streaming argmax/argmin: reduces a valid/ready packet to its extreme value,
// the index of that value's first occurrence, the beat count and an overflow flag.
module stream_argmax #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             u_mod,
  input  logic             min_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_val,
  output logic [IDX_W-1:0] out_idx,
  output logic [IDX_W:0]   out_cnt,
  output logic             out_ovf
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} stateT;

  stateT            state, nextState;
  logic             armed;
  logic [WIDTH-1:0] best, bestNext;
  logic [IDX_W-1:0] idx, idxNext;
  logic [IDX_W:0]   cnt, cntNext;
  logic             ovf, ovfNext;
  logic             uModQ, minModeQ;
  logic             accept, full, replace;
  logic [WIDTH-1:0] keyIn, keyBest;

  // armed keeps in_ready low until the first clock edge after reset release
  assign in_ready  = armed & (state != DONE);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == DONE);
  assign full      = cnt[IDX_W];

  // Flipping the MSB maps two's-complement order onto unsigned order
  assign keyIn   = {in_data[WIDTH-1] ^ ~uModQ, in_data[WIDTH-2:0]};
  assign keyBest = {best[WIDTH-1] ^ ~uModQ, best[WIDTH-2:0]};
  assign replace = minModeQ ? (keyIn < keyBest) : (keyIn > keyBest);

  always_comb begin
    nextState = state;
    bestNext  = best;
    idxNext   = idx;
    cntNext   = cnt;
    ovfNext   = ovf;
    case (state)
      IDLE: begin
        if (accept) begin
          bestNext  = in_data;
          idxNext   = '0;
          cntNext   = (IDX_W+1)'(1);
          ovfNext   = 1'b0;
          nextState = in_last ? DONE : ACC;
        end
      end
      ACC: begin
        if (accept) begin
          // Once the packet is full, further beats only raise the overflow flag
          if (full) begin
            ovfNext = 1'b1;
          end else begin
            cntNext = cnt + (IDX_W+1)'(1);
            if (replace) begin
              bestNext = in_data;
              idxNext  = cnt[IDX_W-1:0];
            end
          end
          if (in_last) nextState = DONE;
        end
      end
      DONE: begin
        if (out_ready) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      armed    <= 1'b0;
      best     <= '0;
      idx      <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      uModQ    <= 1'b0;
      minModeQ <= 1'b0;
      out_val  <= '0;
      out_idx  <= '0;
      out_cnt  <= '0;
      out_ovf  <= 1'b0;
    end else begin
      armed <= 1'b1;
      state <= nextState;
      best  <= bestNext;
      idx   <= idxNext;
      cnt   <= cntNext;
      ovf   <= ovfNext;
      if (state == IDLE && accept) begin
        uModQ    <= u_mod;
        minModeQ <= min_mode;
      end
      // Result registers only change at the closing beat, so they hold between packets
      if (accept && in_last) begin
        out_val <= bestNext;
        out_idx <= idxNext;
        out_cnt <= cntNext;
        out_ovf <= ovfNext;
      end
    end
  end

endmodule

// File: tb/tb_stream_argmax.sv
// Bench for stream_argmax: a default-size instance and a 4-element instance share
// the stimulus; results are checked against a queue-based reference model.
module tb_stream_argmax;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inValid = 1'b0;
  logic        inLast = 1'b0;
  logic        uMod = 1'b0;
  logic        minMode = 1'b0;
  logic        outReady = 1'b0;
  logic        sel = 1'b0;
  logic [31:0] inData = '0;

  logic        readyA, validA, ovfA;
  logic [31:0] valA;
  logic [7:0]  idxA;
  logic [8:0]  cntA;
  logic        readyB, validB, ovfB;
  logic [31:0] valB;
  logic [1:0]  idxB;
  logic [2:0]  cntB;

  logic        curReady, curValid, curOvf;
  logic [31:0] curVal, curIdx, curCnt;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  logic [31:0] expVal;
  int          expIdx, expCnt;
  logic        expOvf;

  always #5 clk = ~clk;

  stream_argmax dutA (
    .clk(clk), .rst_n(rst_n),
    .in_valid(inValid & ~sel), .in_ready(readyA), .in_data(inData), .in_last(inLast),
    .u_mod(uMod), .min_mode(minMode),
    .out_valid(validA), .out_ready(outReady & ~sel),
    .out_val(valA), .out_idx(idxA), .out_cnt(cntA), .out_ovf(ovfA)
  );

  stream_argmax #(.WIDTH(32), .IDX_W(2)) dutB (
    .clk(clk), .rst_n(rst_n),
    .in_valid(inValid & sel), .in_ready(readyB), .in_data(inData), .in_last(inLast),
    .u_mod(uMod), .min_mode(minMode),
    .out_valid(validB), .out_ready(outReady & sel),
    .out_val(valB), .out_idx(idxB), .out_cnt(cntB), .out_ovf(ovfB)
  );

  always_comb begin
    curReady = sel ? readyB : readyA;
    curValid = sel ? validB : validA;
    curOvf   = sel ? ovfB : ovfA;
    curVal   = sel ? valB : valA;
    curIdx   = sel ? 32'(idxB) : 32'(idxA);
    curCnt   = sel ? 32'(cntB) : 32'(cntA);
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    assert (obs === exp) begin
      passCount++;
    end else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // First extreme among the first `limit` beats; extra beats only mark overflow
  task automatic refModel(input logic [31:0] beats[$], input logic u, input logic m, input int limit);
    expCnt = (beats.size() > limit) ? limit : beats.size();
    expOvf = (beats.size() > limit);
    expVal = beats[0];
    expIdx = 0;
    for (int k = 1; k < expCnt; k++) begin
      bit better;
      if (u) better = m ? (beats[k] < expVal) : (beats[k] > expVal);
      else   better = m ? ($signed(beats[k]) < $signed(expVal)) : ($signed(beats[k]) > $signed(expVal));
      if (better) begin
        expVal = beats[k];
        expIdx = k;
      end
    end
  endtask

  task automatic sendBeat(input logic [31:0] d, input logic last, input logic u, input logic m, input string tag);
    int t = 0;
    inValid = 1'b1;
    inData  = d;
    inLast  = last;
    uMod    = u;
    minMode = m;
    while (!curReady && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!curReady) checkOutput({tag, ".readyTimeout"}, 0, 1);
    @(negedge clk);
  endtask

  task automatic checkResult(input string tag);
    checkOutput({tag, ".valid"}, curValid, 1);
    checkOutput({tag, ".val"}, curVal, expVal);
    checkOutput({tag, ".idx"}, curIdx, expIdx);
    checkOutput({tag, ".cnt"}, curCnt, expCnt);
    checkOutput({tag, ".ovf"}, curOvf, expOvf);
    checkOutput({tag, ".inReadyLow"}, curReady, 0);
  endtask

  task automatic handoff(input string tag);
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
    checkOutput({tag, ".validDrop"}, curValid, 0);
  endtask

  // Mode inputs are scrambled after the first beat; the DUT must ignore that
  task automatic applyStimulus(input logic [31:0] beats[$], input logic u, input logic m,
                               input logic doHandoff, input string tag);
    refModel(beats, u, m, sel ? 4 : 256);
    foreach (beats[k]) begin
      if (k == 0) sendBeat(beats[k], k == beats.size() - 1, u, m, tag);
      else sendBeat(beats[k], k == beats.size() - 1, 1'($urandom), 1'($urandom), tag);
    end
    inValid = 1'b0;
    inLast  = 1'b0;
    checkResult(tag);
    if (doHandoff) handoff(tag);
  endtask

  task automatic resetPulse(input string tag);
    inValid = 1'b0;
    inLast  = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput({tag, ".valid"}, validA, 0);
    checkOutput({tag, ".val"}, valA, 0);
    checkOutput({tag, ".idx"}, idxA, 0);
    checkOutput({tag, ".cnt"}, cntA, 0);
    checkOutput({tag, ".ovf"}, ovfA, 0);
    checkOutput({tag, ".ready"}, readyA, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput({tag, ".readyAfterRelease"}, readyA, 0);
    @(negedge clk);
    checkOutput({tag, ".readyFirstClock"}, readyA, 1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] q[$];
    logic [31:0] heldVal;

    // Reset state
    @(negedge clk);
    checkOutput("reset.validA", validA, 0);
    checkOutput("reset.readyA", readyA, 0);
    checkOutput("reset.readyB", readyB, 0);
    checkOutput("reset.valA", valA, 0);
    checkOutput("reset.cntA", cntA, 0);
    rst_n = 1'b1;
    #1;
    checkOutput("release.readyA", readyA, 0);
    @(negedge clk);
    checkOutput("firstClock.readyA", readyA, 1);

    // Directed packets
    q = '{32'd5, 32'hFFFF_FFFD, 32'd7, 32'd7, 32'd2};
    applyStimulus(q, 1'b0, 1'b0, 1'b1, "signedMax");
    checkOutput("signedMax.const", {curVal, curIdx}, {32'd7, 32'd2});
    q = '{32'h0000_0001, 32'hFFFF_FFFF};
    applyStimulus(q, 1'b1, 1'b0, 1'b1, "unsignedMax");
    applyStimulus(q, 1'b0, 1'b0, 1'b1, "signedMaxNeg");
    q = '{32'd0, 32'hFFFF_FFF8, 32'd4, 32'hFFFF_FFF8};
    applyStimulus(q, 1'b0, 1'b1, 1'b1, "signedMinTie");
    q = '{32'd9};
    applyStimulus(q, 1'b0, 1'b0, 1'b1, "singleBeat");

    sel = 1'b1;
    q = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd9, 32'd9};
    applyStimulus(q, 1'b1, 1'b0, 1'b1, "overflow");
    checkOutput("overflow.const", {curVal, curIdx}, {32'd4, 32'd3});
    q = '{32'd8, 32'd8, 32'd8, 32'd8};
    applyStimulus(q, 1'b1, 1'b0, 1'b1, "exactFull");
    sel = 1'b0;

    // Backpressure: result must stay put and incoming beats be ignored
    q = '{32'd3, 32'hFFFF_FF00, 32'd11};
    applyStimulus(q, 1'b0, 1'b0, 1'b0, "hold");
    heldVal = expVal;
    inValid = 1'b1;
    inData  = 32'd42;
    inLast  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("hold.valid", validA, 1);
      checkOutput("hold.val", valA, heldVal);
      checkOutput("hold.cnt", cntA, 3);
      checkOutput("hold.ready", readyA, 0);
    end
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
    checkOutput("hold.validDrop", validA, 0);
    checkOutput("hold.readyBack", readyA, 1);
    @(negedge clk);
    inValid = 1'b0;
    inLast  = 1'b0;
    expVal = 32'd42; expIdx = 0; expCnt = 1; expOvf = 1'b0;
    checkResult("nextAfterHold");
    handoff("nextAfterHold");

    // Reset mid-packet, then in DONE
    sendBeat(32'd100, 1'b0, 1'b0, 1'b0, "midPkt");
    sendBeat(32'd200, 1'b0, 1'b0, 1'b0, "midPkt");
    sendBeat(32'd300, 1'b0, 1'b0, 1'b0, "midPkt");
    resetPulse("resetMid");
    q = '{32'd3};
    applyStimulus(q, 1'b0, 1'b0, 1'b1, "afterResetMid");
    q = '{32'd5, 32'd6};
    applyStimulus(q, 1'b0, 1'b0, 1'b0, "preResetDone");
    resetPulse("resetDone");

    // Randomized packets, some on the small instance to reach overflow
    for (int p = 0; p < 40; p++) begin
      int len;
      sel = (p % 4 == 3);
      len = $urandom_range(1, sel ? 7 : 10);
      q.delete();
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 1) == 1) q.push_back($urandom);
        else q.push_back(32'($urandom_range(0, 8)) - 32'd4);
      end
      applyStimulus(q, 1'($urandom), 1'($urandom), 1'b1, $sformatf("rand%0d", p));
    end
    sel = 1'b0;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
